// File: rtl/riu_pkg.sv
// Shared RIU ISA constants: itype codes, ALU op enum, RV32IM opcode/funct fields,
// and the descriptor record passed from the loader to the encoder.
package riu_pkg;

    localparam logic [2:0] ITYPE_R = 3'b000;
    localparam logic [2:0] ITYPE_I = 3'b001;
    localparam logic [2:0] ITYPE_U = 3'b010;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRA   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULH  = 4'd11,
        ALU_MULHU = 4'd12,
        ALU_CSRRW = 4'd13
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SLT   = 3'b010;
    localparam logic [2:0] F3_SLTU  = 3'b011;
    localparam logic [2:0] F3_XOR   = 3'b100;
    localparam logic [2:0] F3_SR    = 3'b101;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;
    localparam logic [2:0] F3_MUL   = 3'b000;
    localparam logic [2:0] F3_MULH  = 3'b001;
    localparam logic [2:0] F3_MULHU = 3'b011;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULT = 7'b0000001;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  itype;
        logic [3:0]  instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [19:0] imm;
    } desc_t;

endpackage

// File: rtl/instr_encode.sv
// Combinational descriptor -> RV32IM word encoder; flags descriptors that have no encoding.
module instr_encode
    import riu_pkg::*;
(
    input  desc_t       desc,
    output logic [31:0] word,
    output logic        illegal
);

    logic [2:0] f3;
    logic [6:0] f7;

    always_comb begin
        f3 = F3_ADD;
        f7 = F7_BASE;
        case (desc.instr)
            ALU_ADD:   f3 = F3_ADD;
            ALU_SUB:   begin f3 = F3_ADD; f7 = F7_ALT; end
            ALU_AND:   f3 = F3_AND;
            ALU_OR:    f3 = F3_OR;
            ALU_XOR:   f3 = F3_XOR;
            ALU_SLL:   f3 = F3_SLL;
            ALU_SRA:   begin f3 = F3_SR; f7 = F7_ALT; end
            ALU_SRL:   f3 = F3_SR;
            ALU_SLT:   f3 = F3_SLT;
            ALU_SLTU:  f3 = F3_SLTU;
            ALU_MUL:   begin f3 = F3_MUL;   f7 = F7_MULT; end
            ALU_MULH:  begin f3 = F3_MULH;  f7 = F7_MULT; end
            ALU_MULHU: begin f3 = F3_MULHU; f7 = F7_MULT; end
            default:   f3 = F3_CSRRW;
        endcase
    end

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (desc.itype)
            ITYPE_R: begin
                if (desc.instr == ALU_CSRRW)
                    word = {desc.imm[11:0], desc.rs1, F3_CSRRW, desc.rd, OPC_SYSTEM};
                else if (desc.instr > ALU_CSRRW)
                    illegal = 1'b1;
                else
                    word = {f7, desc.rs2, desc.rs1, f3, desc.rd, OPC_OP};
            end
            ITYPE_I: begin
                case (desc.instr)
                    ALU_ADD, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU:
                        word = {desc.imm[11:0], desc.rs1, f3, desc.rd, OPC_OP_IMM};
                    // Shifts carry shamt in the rs2 slot; f7 already selects arith vs logical
                    ALU_SLL, ALU_SRL, ALU_SRA:
                        word = {f7, desc.imm[4:0], desc.rs1, f3, desc.rd, OPC_OP_IMM};
                    default: illegal = 1'b1;
                endcase
            end
            ITYPE_U: word = {desc.imm, desc.rd, OPC_LUI};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams encoded descriptors into instruction memory at auto-incrementing addresses.
// Build option INSTR_ENC_NOP_FILL_EN: illegal descriptors write a NOP instead of being skipped.
module instr_encode_loader
    import riu_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_itype,
    input  logic [3:0]    in_instr,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [19:0]   in_imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_e;

    state_e      state, state_nxt;
    desc_t       desc;
    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        hs, wr;
    logic [31:0] wr_data;

    assign desc = '{itype: in_itype, instr: in_instr, rd: in_rd,
                    rs1: in_rs1, rs2: in_rs2, imm: in_imm};

    instr_encode u_enc (
        .desc    (desc),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready = (state == LOAD);
    assign full     = (state == FULL);
    // start wins over a same-cycle handshake, so that descriptor is dropped
    assign hs       = in_valid & in_ready & ~start;

`ifdef INSTR_ENC_NOP_FILL_EN
    assign wr      = hs;
    assign wr_data = enc_illegal ? NOP_WORD : enc_word;
`else
    assign wr      = hs & ~enc_illegal;
    assign wr_data = enc_word;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: if (!start && wr && count == (AW+1)'(DEPTH - 1)) state_nxt = FULL;
            FULL: if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            state   <= state_nxt;
            imem_we <= 1'b0;
            err     <= hs & enc_illegal;
            if (start) begin
                count     <= '0;
                imem_addr <= '0;
            end else if (wr) begin
                imem_we    <= 1'b1;
                imem_addr  <= count[AW-1:0];
                imem_wdata <= wr_data;
                count      <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader (DEPTH=4): encoding table plus handshake corner sequences.
module tb_instr_encode_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready;
    logic [2:0]    in_itype;
    logic [3:0]    in_instr;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [19:0]   in_imm;
    logic          imem_we, full, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    int n_chk  = 0;
    int n_fail = 0;

    instr_encode_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_itype(in_itype), .in_instr(in_instr), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  itype;
        logic [3:0]  instr;
        logic [4:0]  rd, rs1, rs2;
        logic [19:0] imm;
        logic        illegal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[$];

`ifdef INSTR_ENC_NOP_FILL_EN
    localparam bit NOP_FILL = 1'b1;
`else
    localparam bit NOP_FILL = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] it, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [19:0] imm);
        in_itype = it; in_instr = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".we"},     32'(imem_we),    32'd0);
        chk({tag, ".addr"},   32'(imem_addr),  32'd0);
        chk({tag, ".wdata"},  imem_wdata,      32'd0);
        chk({tag, ".count"},  32'(count),      32'd0);
        chk({tag, ".full"},   32'(full),       32'd0);
        chk({tag, ".err"},    32'(err),        32'd0);
        chk({tag, ".ready"},  32'(in_ready),   32'd0);
    endtask

    initial begin
        vecs.push_back('{"add_r",    3'd0, 4'd0,  5'd1,  5'd2,  5'd3,  20'h0,     1'b0, 32'h003100B3});
        vecs.push_back('{"sub_r",    3'd0, 4'd1,  5'd5,  5'd6,  5'd7,  20'h0,     1'b0, 32'h407302B3});
        vecs.push_back('{"sra_i",    3'd1, 4'd6,  5'd1,  5'd1,  5'd0,  20'h3,     1'b0, 32'h4030D093});
        vecs.push_back('{"lui",      3'd2, 4'd0,  5'd10, 5'd0,  5'd0,  20'h12345, 1'b0, 32'h12345537});
        vecs.push_back('{"csrrw",    3'd0, 4'd13, 5'd0,  5'd4,  5'd0,  20'h780,   1'b0, 32'h78021073});
        vecs.push_back('{"and_r",    3'd0, 4'd2,  5'd3,  5'd4,  5'd5,  20'h0,     1'b0, 32'h005271B3});
        vecs.push_back('{"andi",     3'd1, 4'd2,  5'd2,  5'd1,  5'd0,  20'hFFF,   1'b0, 32'hFFF0F113});
        vecs.push_back('{"slli",     3'd1, 4'd5,  5'd7,  5'd8,  5'd0,  20'hFFFE5, 1'b0, 32'h00541393});
        vecs.push_back('{"sltiu",    3'd1, 4'd9,  5'd31, 5'd31, 5'd0,  20'h800,   1'b0, 32'h800FBF93});
        vecs.push_back('{"mulhu",    3'd0, 4'd12, 5'd9,  5'd10, 5'd11, 20'h0,     1'b0, 32'h02B534B3});
        vecs.push_back('{"srl_r",    3'd0, 4'd7,  5'd1,  5'd2,  5'd3,  20'h0,     1'b0, 32'h003150B3});
        vecs.push_back('{"lui_op15", 3'd2, 4'd15, 5'd0,  5'd0,  5'd0,  20'hFFFFF, 1'b0, 32'hFFFFF037});
        vecs.push_back('{"i_sub",    3'd1, 4'd1,  5'd1,  5'd2,  5'd3,  20'h5,     1'b1, 32'h00000013});
        vecs.push_back('{"i_mul",    3'd1, 4'd10, 5'd1,  5'd2,  5'd3,  20'h5,     1'b1, 32'h00000013});
        vecs.push_back('{"i_csrrw",  3'd1, 4'd13, 5'd1,  5'd2,  5'd3,  20'h5,     1'b1, 32'h00000013});
        vecs.push_back('{"r_op14",   3'd0, 4'd14, 5'd1,  5'd2,  5'd3,  20'h0,     1'b1, 32'h00000013});
        vecs.push_back('{"itype3",   3'd3, 4'd0,  5'd1,  5'd2,  5'd3,  20'h0,     1'b1, 32'h00000013});
        vecs.push_back('{"itype7",   3'd7, 4'd0,  5'd1,  5'd2,  5'd3,  20'h0,     1'b1, 32'h00000013});

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        drive(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 20'h0);
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk("idle.ready", 32'(in_ready), 32'd0);

        // Table: each vector is a lone handshake right after start, so it lands at addr 0.
        foreach (vecs[i]) begin
            pulse_start();
            chk({vecs[i].name, ".ready"}, 32'(in_ready), 32'd1);
            drive(vecs[i].itype, vecs[i].instr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk({vecs[i].name, ".err"}, 32'(err), 32'(vecs[i].illegal));
            if (!vecs[i].illegal || NOP_FILL) begin
                chk({vecs[i].name, ".we"},    32'(imem_we),   32'd1);
                chk({vecs[i].name, ".addr"},  32'(imem_addr), 32'd0);
                chk({vecs[i].name, ".wdata"}, imem_wdata,     vecs[i].word);
                chk({vecs[i].name, ".count"}, 32'(count),     32'd1);
            end else begin
                chk({vecs[i].name, ".we"},    32'(imem_we),   32'd0);
                chk({vecs[i].name, ".count"}, 32'(count),     32'd0);
            end
            step();
            chk({vecs[i].name, ".err_pulse"}, 32'(err),     32'd0);
            chk({vecs[i].name, ".we_pulse"},  32'(imem_we), 32'd0);
        end

        // Back-to-back sub, sra, then an illegal descriptor mid-stream.
        pulse_start();
        in_valid = 1'b1;
        drive(3'd0, 4'd1, 5'd5, 5'd6, 5'd7, 20'h0);
        step();
        chk("b2b0.we", 32'(imem_we), 32'd1);
        chk("b2b0.addr", 32'(imem_addr), 32'd0);
        chk("b2b0.wdata", imem_wdata, 32'h407302B3);
        drive(3'd1, 4'd6, 5'd1, 5'd1, 5'd0, 20'h3);
        step();
        chk("b2b1.we", 32'(imem_we), 32'd1);
        chk("b2b1.addr", 32'(imem_addr), 32'd1);
        chk("b2b1.wdata", imem_wdata, 32'h4030D093);
        chk("b2b1.count", 32'(count), 32'd2);
        drive(3'd1, 4'd1, 5'd1, 5'd2, 5'd3, 20'h0);
        step();
        in_valid = 1'b0;
        chk("ill.err", 32'(err), 32'd1);
        chk("ill.we", 32'(imem_we), 32'(NOP_FILL));
        chk("ill.count", 32'(count), NOP_FILL ? 32'd3 : 32'd2);
        if (NOP_FILL) begin
            chk("ill.addr", 32'(imem_addr), 32'd2);
            chk("ill.wdata", imem_wdata, 32'h00000013);
        end

        // Fill to DEPTH with in_valid held for 6 descriptors.
        pulse_start();
        chk("fill.count0", 32'(count), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(3'd0, 4'd0, 5'(i + 1), 5'd2, 5'd3, 20'h0);
            step();
            if (i < DEPTH) begin
                chk($sformatf("fill%0d.we", i), 32'(imem_we), 32'd1);
                chk($sformatf("fill%0d.addr", i), 32'(imem_addr), 32'(i));
                chk($sformatf("fill%0d.wdata", i), imem_wdata,
                    {12'h003, 5'd2, 3'b000, 5'(i + 1), 7'b0110011});
                chk($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
            end else begin
                chk($sformatf("fill%0d.we", i), 32'(imem_we), 32'd0);
                chk($sformatf("fill%0d.count", i), 32'(count), 32'd4);
            end
            chk($sformatf("fill%0d.full", i), 32'(full), (i >= DEPTH - 1) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d.ready", i), 32'(in_ready), (i < DEPTH - 1) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        pulse_start();
        chk("restart.full", 32'(full), 32'd0);
        chk("restart.count", 32'(count), 32'd0);
        chk("restart.ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        drive(3'd2, 4'd0, 5'd10, 5'd0, 5'd0, 20'h12345);
        step();
        chk("restart.we", 32'(imem_we), 32'd1);
        chk("restart.addr", 32'(imem_addr), 32'd0);
        chk("restart.wdata", imem_wdata, 32'h12345537);

        // start together with a valid descriptor: descriptor dropped, count cleared.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("startpri.we", 32'(imem_we), 32'd0);
        chk("startpri.count", 32'(count), 32'd0);
        step();
        chk("startpri.next_addr", 32'(imem_addr), 32'd0);
        chk("startpri.next_count", 32'(count), 32'd1);

        // Async reset mid-stream with in_valid still high.
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        step();
        chk_all_zero("rst_mid");
        rst = 1'b0;
        step(); step();
        chk("rst_after.we", 32'(imem_we), 32'd0);
        chk("rst_after.ready", 32'(in_ready), 32'd0);
        chk("rst_after.count", 32'(count), 32'd0);
        pulse_start();
        step();
        chk("rst_start.we", 32'(imem_we), 32'd1);
        chk("rst_start.addr", 32'(imem_addr), 32'd0);
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
